// File: rtl/led_mode_controller_if.sv
// Switch and LED signal bundle for led_mode_controller.
// The master side drives the active-low switches; the slave side (the
// controller) drives the LED outputs and reports the current modes.
interface led_mode_controller_if;
  logic       switch1;
  logic       switch2;
  logic       switch4;
  logic       led_green;
  logic       led_blue;
  logic [1:0] mode_green;
  logic [1:0] mode_blue;

  modport master (
    output switch1, switch2, switch4,
    input  led_green, led_blue, mode_green, mode_blue
  );

  modport slave (
    input  switch1, switch2, switch4,
    output led_green, led_blue, mode_green, mode_blue
  );
endinterface

// File: rtl/led_mode_controller.sv
// Two-LED mode controller: three debounced active-low switches step the
// green/blue mode FSMs (OFF -> ON -> SLOW -> FAST -> OFF) or force both OFF,
// and a free-running shared timebase drives the blink patterns.
module led_mode_controller #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TICK_DIV        = 1500000
) (
  input logic                  CLOCK,
  input logic                  RESET_N,
  led_mode_controller_if.slave led_if
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    M_OFF  = 2'd0,
    M_ON   = 2'd1,
    M_SLOW = 2'd2,
    M_FAST = 2'd3
  } mode_e;

  // Bit 0 = switch1 (green), bit 1 = switch2 (blue), bit 2 = switch4 (all off).
  logic [2:0]    sw_raw;
  logic [2:0]    sync1_q;
  logic [2:0]    sync2_q;
  logic [2:0]    level_q;
  logic [2:0]    arm_q;
  logic [2:0]    press_q;
  logic [1:0]    vld_q;
  logic [DW-1:0] cnt_q [3];

  mode_e         mode_green_q;
  mode_e         mode_blue_q;

  logic [PW-1:0] presc_q;
  logic [2:0]    phase_q;
  logic          tick;

  logic          led_green_q;
  logic          led_blue_q;

  assign sw_raw = {led_if.switch4, led_if.switch2, led_if.switch1};
  assign tick   = (presc_q == TICK_LAST);

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      M_OFF:   next_mode = M_ON;
      M_ON:    next_mode = M_SLOW;
      M_SLOW:  next_mode = M_FAST;
      default: next_mode = M_OFF;
    endcase
  endfunction

  function automatic logic led_value(input mode_e m, input logic [2:0] ph);
    case (m)
      M_OFF:   led_value = 1'b0;
      M_ON:    led_value = 1'b1;
      M_SLOW:  led_value = ph[2];
      default: led_value = ph[0];
    endcase
  endfunction

  // Synchronize, debounce and edge-detect each switch. vld_q marks when the
  // synchronizer holds real post-reset samples; a switch only becomes armed
  // once it is seen released, so a switch held through reset raises no event
  // until it is released and pressed again.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= '1;
      sync2_q <= '1;
      level_q <= '1;
      arm_q   <= '0;
      press_q <= '0;
      vld_q   <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
      for (int i = 0; i < 3; i++) begin
        press_q[i] <= 1'b0;
        if (vld_q[1] && sync2_q[i]) arm_q[i] <= 1'b1;
        if (sync2_q[i] == level_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DB_LAST) begin
          level_q[i] <= sync2_q[i];
          cnt_q[i]   <= '0;
          press_q[i] <= ~sync2_q[i] & arm_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Mode FSMs: switch4 forces both OFF and beats any same-cycle step event.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_green_q <= M_OFF;
      mode_blue_q  <= M_OFF;
    end else if (press_q[2]) begin
      mode_green_q <= M_OFF;
      mode_blue_q  <= M_OFF;
    end else begin
      if (press_q[0]) mode_green_q <= next_mode(mode_green_q);
      if (press_q[1]) mode_blue_q  <= next_mode(mode_blue_q);
    end
  end

  // Shared free-running timebase; never restarted so blinking LEDs stay aligned.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      presc_q <= '0;
      phase_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
      phase_q <= phase_q + 3'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Registered LED drives, one cycle behind the mode and phase registers.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      led_green_q <= 1'b0;
      led_blue_q  <= 1'b0;
    end else begin
      led_green_q <= led_value(mode_green_q, phase_q);
      led_blue_q  <= led_value(mode_blue_q, phase_q);
    end
  end

  assign led_if.led_green  = led_green_q;
  assign led_if.led_blue   = led_blue_q;
  assign led_if.mode_green = mode_green_q;
  assign led_if.mode_blue  = mode_blue_q;

endmodule

// File: tb/tb_led_mode_controller.sv
// Directed bench for led_mode_controller with DEBOUNCE_CYCLES=4, TICK_DIV=3.
module tb_led_mode_controller;

  localparam int DB = 4;
  localparam int TD = 3;

  logic CLOCK;
  logic RESET_N;
  int   n_cmp;
  int   n_err;

  led_mode_controller_if led_if ();

  led_mode_controller #(
    .DEBOUNCE_CYCLES (DB),
    .TICK_DIV        (TD)
  ) dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .led_if  (led_if)
  );

  // Clock and reset
  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Advance one edge and settle 1 time unit past it before looking at outputs.
  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_sw(input int idx, input logic v);
    case (idx)
      1:       led_if.switch1 = v;
      2:       led_if.switch2 = v;
      default: led_if.switch4 = v;
    endcase
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    repeat (3) step();
    RESET_N = 1'b1;
    repeat (5) step();
  endtask

  // One clean press: held well past the debounce window, then released.
  task automatic press(input int idx);
    set_sw(idx, 1'b0);
    repeat (DB + 6) step();
    set_sw(idx, 1'b1);
    repeat (DB + 6) step();
  endtask

  // Cycles until led_blue next changes; returns 40 if it never does.
  task automatic wait_toggle(output int n);
    logic prev;
    prev = led_if.led_blue;
    n = 0;
    while (n < 40) begin
      step();
      n++;
      if (led_if.led_blue !== prev) break;
    end
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_err = 0;
    led_if.switch1 = 1'b1;
    led_if.switch2 = 1'b1;
    led_if.switch4 = 1'b1;
    RESET_N = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_mode_green", 8'(led_if.mode_green), 8'd0);
    check("rst_mode_blue",  8'(led_if.mode_blue),  8'd0);
    check("rst_led_green",  8'(led_if.led_green),  8'd0);
    check("rst_led_blue",   8'(led_if.led_blue),   8'd0);
    RESET_N = 1'b1;
    repeat (5) step();

    // Held switch1: mode moves on the 7th edge, LED on the 8th, then nothing more
    led_if.switch1 = 1'b0;
    repeat (6) step();
    check("lat_mode_e6", 8'(led_if.mode_green), 8'd0);
    step();
    check("lat_mode_e7", 8'(led_if.mode_green), 8'd1);
    check("lat_led_e7",  8'(led_if.led_green),  8'd0);
    step();
    check("lat_led_e8",  8'(led_if.led_green),  8'd1);
    repeat (20) step();
    check("held_mode", 8'(led_if.mode_green), 8'd1);
    led_if.switch1 = 1'b1;
    repeat (10) step();
    check("release_mode", 8'(led_if.mode_green), 8'd1);

    // Bounce shorter than the debounce window never registers
    do_reset();
    led_if.switch1 = 1'b0;
    repeat (3) begin step(); check("bounce_a", 8'(led_if.mode_green), 8'd0); end
    led_if.switch1 = 1'b1;
    step();
    check("bounce_b", 8'(led_if.mode_green), 8'd0);
    led_if.switch1 = 1'b0;
    repeat (3) begin step(); check("bounce_c", 8'(led_if.mode_green), 8'd0); end
    led_if.switch1 = 1'b1;
    repeat (10) begin step(); check("bounce_d", 8'(led_if.mode_green), 8'd0); end

    // switch2 sequence through all four modes, with blink periods
    press(2);
    check("blue_m1", 8'(led_if.mode_blue), 8'd1);
    check("blue_led_on", 8'(led_if.led_blue), 8'd1);
    press(2);
    check("blue_m2", 8'(led_if.mode_blue), 8'd2);
    wait_toggle(n);
    wait_toggle(n);
    check("slow_half_a", 8'(n), 8'd12);
    wait_toggle(n);
    check("slow_half_b", 8'(n), 8'd12);
    press(2);
    check("blue_m3", 8'(led_if.mode_blue), 8'd3);
    wait_toggle(n);
    wait_toggle(n);
    check("fast_half_a", 8'(n), 8'd3);
    wait_toggle(n);
    check("fast_half_b", 8'(n), 8'd3);
    press(2);
    check("blue_m0", 8'(led_if.mode_blue), 8'd0);
    check("blue_led_off", 8'(led_if.led_blue), 8'd0);

    // Both LEDs in SLOW, entered at different times, blink in lockstep
    do_reset();
    press(1);
    press(1);
    repeat (7) step();
    press(2);
    press(2);
    check("align_g", 8'(led_if.mode_green), 8'd2);
    check("align_b", 8'(led_if.mode_blue),  8'd2);
    for (int i = 0; i < 40; i++) begin
      step();
      check("align_led", 8'(led_if.led_green), 8'(led_if.led_blue));
    end

    // switch1 and switch4 together: switch4 wins, both modes OFF
    led_if.switch1 = 1'b0;
    led_if.switch4 = 1'b0;
    repeat (6) step();
    check("prio_pre_g", 8'(led_if.mode_green), 8'd2);
    step();
    check("prio_g", 8'(led_if.mode_green), 8'd0);
    check("prio_b", 8'(led_if.mode_blue),  8'd0);
    step();
    check("prio_led_g", 8'(led_if.led_green), 8'd0);
    check("prio_led_b", 8'(led_if.led_blue),  8'd0);
    led_if.switch1 = 1'b1;
    led_if.switch4 = 1'b1;
    repeat (10) step();
    check("prio_after_g", 8'(led_if.mode_green), 8'd0);

    // Reset mid-debounce with switch2 held: needs release and re-press
    press(1);
    press(2);
    check("pre_rst_g", 8'(led_if.mode_green), 8'd1);
    check("pre_rst_b", 8'(led_if.mode_blue),  8'd1);
    led_if.switch2 = 1'b0;
    repeat (3) step();
    #3;
    RESET_N = 1'b0;
    #1;
    check("async_mode_g", 8'(led_if.mode_green), 8'd0);
    check("async_mode_b", 8'(led_if.mode_blue),  8'd0);
    check("async_led_g",  8'(led_if.led_green),  8'd0);
    check("async_led_b",  8'(led_if.led_blue),   8'd0);
    step();
    @(negedge CLOCK);
    RESET_N = 1'b1;
    repeat (20) step();
    check("held_thru_rst", 8'(led_if.mode_blue), 8'd0);
    led_if.switch2 = 1'b1;
    repeat (10) step();
    check("rel_after_rst", 8'(led_if.mode_blue), 8'd0);
    press(2);
    check("repress_b", 8'(led_if.mode_blue), 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
